// File: rtl/pipe_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_ctrl : stall/flush/redirect control and exception sequencing  |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
module pipe_ctrl #(
   parameter logic [31:0] EXP_VECTOR = 32'h0000_0100,
   parameter logic [2:0]  EXP_NO_EXP = 3'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_busy,
   input  logic        mem_busy,
   input  logic [4:0]  ra_addr,
   input  logic [4:0]  rb_addr,
   input  logic        ra_use,
   input  logic        rb_use,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        id_en,
   input  logic        id_load,
   input  logic [4:0]  id_dst_addr,
   input  logic        id_gpr_we_,
   input  logic        ex_en,
   input  logic [31:0] ex_pc,
   input  logic [2:0]  ex_exp_code,
   input  logic        ex_eret,
   output logic        if_stall,
   output logic        id_stall,
   output logic        ex_stall,
   output logic        mem_stall,
   output logic        if_flush,
   output logic        id_flush,
   output logic        ex_flush,
   output logic        mem_flush,
   output logic [31:0] new_pc,
   output logic        new_pc_valid,
   output logic [31:0] epc,
   output logic [2:0]  exp_code_q,
   output logic        in_handler,
   output logic        halted,
   output logic [31:0] stall_cnt
);

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      EXC  = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] epc_q, epc_d;
   logic [2:0]  code_q, code_d;
   logic        inh_q, inh_d;
   logic        halt_q, halt_d;
   logic [31:0] cnt_q, cnt_d;

   logic busy, exc, lu;

   assign busy = if_busy | mem_busy;
   assign exc  = ex_en & (ex_exp_code != EXP_NO_EXP);
   assign lu   = id_en & id_load & ~id_gpr_we_ & (id_dst_addr != 5'd0) &
                 ((ra_use & (ra_addr == id_dst_addr)) |
                  (rb_use & (rb_addr == id_dst_addr)));

   always_comb begin
      if_stall     = 1'b0;
      id_stall     = 1'b0;
      ex_stall     = 1'b0;
      mem_stall    = 1'b0;
      if_flush     = 1'b0;
      id_flush     = 1'b0;
      ex_flush     = 1'b0;
      mem_flush    = 1'b0;
      new_pc       = 32'd0;
      new_pc_valid = 1'b0;
      state_d      = state_q;
      epc_d        = epc_q;
      code_d       = code_q;
      inh_d        = inh_q;
      halt_d       = halt_q;
      if (reset) begin
         if_flush  = 1'b1;
         id_flush  = 1'b1;
         ex_flush  = 1'b1;
         mem_flush = 1'b1;
      end else begin
         case (state_q)
            RUN: begin
               if (busy) begin
                  {if_stall, id_stall, ex_stall, mem_stall} = 4'b1111;
               end else if (exc && !inh_q) begin
                  {if_flush, id_flush, ex_flush, mem_flush} = 4'b1111;
                  new_pc       = EXP_VECTOR;
                  new_pc_valid = 1'b1;
                  epc_d        = ex_pc;
                  code_d       = ex_exp_code;
                  inh_d        = 1'b1;
                  state_d      = EXC;
               end else if (exc) begin
                  {if_flush, id_flush, ex_flush, mem_flush} = 4'b1111;
                  halt_d  = 1'b1;
                  state_d = HALT;
               end else if (ex_eret && ex_en) begin
                  {if_flush, id_flush, ex_flush} = 3'b111;
                  new_pc       = epc_q;
                  new_pc_valid = 1'b1;
                  inh_d        = 1'b0;
               end else if (lu) begin
                  // Branch is deliberately ignored; it re-resolves after the bubble.
                  if_stall = 1'b1;
                  id_flush = 1'b1;
               end else if (br_taken) begin
                  if_flush     = 1'b1;
                  new_pc       = br_target;
                  new_pc_valid = 1'b1;
               end
            end
            EXC: begin
               if (busy) begin
                  {if_stall, id_stall, ex_stall, mem_stall} = 4'b1111;
               end else begin
                  if_flush = 1'b1;
                  state_d  = RUN;
               end
            end
            default: begin
               {if_stall, id_stall, ex_stall, mem_stall} = 4'b1111;
            end
         endcase
      end
      cnt_d = if_stall ? cnt_q + 32'd1 : cnt_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= RUN;
         epc_q   <= 32'd0;
         code_q  <= EXP_NO_EXP;
         inh_q   <= 1'b0;
         halt_q  <= 1'b0;
         cnt_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         epc_q   <= epc_d;
         code_q  <= code_d;
         inh_q   <= inh_d;
         halt_q  <= halt_d;
         cnt_q   <= cnt_d;
      end
   end

   assign epc        = epc_q;
   assign exp_code_q = code_q;
   assign in_handler = inh_q;
   assign halted     = halt_q;
   assign stall_cnt  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pipe_ctrl : directed scoreboard bench for pipe_ctrl             |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_busy, mem_busy;
   logic [4:0]  ra_addr, rb_addr;
   logic        ra_use, rb_use;
   logic        br_taken;
   logic [31:0] br_target;
   logic        id_en, id_load;
   logic [4:0]  id_dst_addr;
   logic        id_gpr_we_;
   logic        ex_en;
   logic [31:0] ex_pc;
   logic [2:0]  ex_exp_code;
   logic        ex_eret;
   logic        if_stall, id_stall, ex_stall, mem_stall;
   logic        if_flush, id_flush, ex_flush, mem_flush;
   logic [31:0] new_pc;
   logic        new_pc_valid;
   logic [31:0] epc;
   logic [2:0]  exp_code_q;
   logic        in_handler, halted;
   logic [31:0] stall_cnt;

   pipe_ctrl dut (
      .clk(clk), .reset(reset), .if_busy(if_busy), .mem_busy(mem_busy),
      .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_use(ra_use), .rb_use(rb_use),
      .br_taken(br_taken), .br_target(br_target), .id_en(id_en), .id_load(id_load),
      .id_dst_addr(id_dst_addr), .id_gpr_we_(id_gpr_we_), .ex_en(ex_en), .ex_pc(ex_pc),
      .ex_exp_code(ex_exp_code), .ex_eret(ex_eret),
      .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
      .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
      .new_pc(new_pc), .new_pc_valid(new_pc_valid), .epc(epc), .exp_code_q(exp_code_q),
      .in_handler(in_handler), .halted(halted), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // Strobe vectors are packed {mem, ex, id, if}.
   typedef struct packed {
      logic [3:0]  stl;
      logic [3:0]  fls;
      logic        npv;
      logic [31:0] npc;
      logic [31:0] epc;
      logic [2:0]  code;
      logic        inh;
      logic        hlt;
      logic [31:0] cnt;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   stepno = 0;

   function automatic exp_t mk(logic [3:0] stl, logic [3:0] fls, logic npv, logic [31:0] npc,
                               logic [31:0] e, logic [2:0] c, logic inh, logic hlt,
                               logic [31:0] cnt);
      exp_t r;
      r.stl = stl; r.fls = fls; r.npv = npv; r.npc = npc; r.epc = e;
      r.code = c; r.inh = inh; r.hlt = hlt; r.cnt = cnt;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL step %0d %s observed %h expected %h", stepno, tag, obs, expv);
      end
   endtask

   task automatic step(input exp_t e);
      exp_t x;
      q.push_back(e);
      @(negedge clk);
      x = q.pop_front();
      chk("stalls", {28'd0, mem_stall, ex_stall, id_stall, if_stall}, {28'd0, x.stl});
      chk("flushes", {28'd0, mem_flush, ex_flush, id_flush, if_flush}, {28'd0, x.fls});
      chk("new_pc_valid", {31'd0, new_pc_valid}, {31'd0, x.npv});
      chk("new_pc", new_pc, x.npc);
      chk("epc", epc, x.epc);
      chk("exp_code_q", {29'd0, exp_code_q}, {29'd0, x.code});
      chk("in_handler", {31'd0, in_handler}, {31'd0, x.inh});
      chk("halted", {31'd0, halted}, {31'd0, x.hlt});
      chk("stall_cnt", stall_cnt, x.cnt);
      stepno++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      if_busy = 0; mem_busy = 0; ra_addr = 0; rb_addr = 0; ra_use = 0; rb_use = 0;
      br_taken = 0; br_target = 0; id_en = 0; id_load = 0; id_dst_addr = 0;
      id_gpr_we_ = 1; ex_en = 0; ex_pc = 0; ex_exp_code = 0; ex_eret = 0;
   endtask

   initial begin
      logic [31:0] cnt;
      reset = 1;
      idle_inputs();
      #1;
      step(mk(4'b0000, 4'b1111, 0, 0, 0, 0, 0, 0, 0));
      reset = 0;
      step(mk(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0));

      // Load-use on ra with a simultaneous taken branch: stall wins, no redirect.
      id_en = 1; id_load = 1; id_gpr_we_ = 0; id_dst_addr = 5; ra_addr = 5; ra_use = 1;
      br_taken = 1; br_target = 32'h40;
      step(mk(4'b0001, 4'b0010, 0, 0, 0, 0, 0, 0, 0));
      // Load to r0 never hazards.
      id_dst_addr = 0; ra_addr = 0; br_taken = 0;
      step(mk(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 1));
      id_en = 0; id_load = 0; id_gpr_we_ = 1; ra_use = 0;
      br_taken = 1; br_target = 32'h40;
      step(mk(4'b0000, 4'b0001, 1, 32'h40, 0, 0, 0, 0, 1));
      br_taken = 0;
      id_en = 1; id_load = 1; id_gpr_we_ = 0; id_dst_addr = 7; rb_addr = 7; rb_use = 1;
      step(mk(4'b0001, 4'b0010, 0, 0, 0, 0, 0, 0, 1));

      // Exception held off by mem_busy for three cycles.
      idle_inputs();
      ex_en = 1; ex_exp_code = 3'd2; ex_pc = 32'h1C; mem_busy = 1;
      step(mk(4'b1111, 4'b0000, 0, 0, 0, 0, 0, 0, 2));
      step(mk(4'b1111, 4'b0000, 0, 0, 0, 0, 0, 0, 3));
      step(mk(4'b1111, 4'b0000, 0, 0, 0, 0, 0, 0, 4));
      mem_busy = 0;
      step(mk(4'b0000, 4'b1111, 1, 32'h100, 0, 0, 0, 0, 5));
      ex_en = 0; ex_exp_code = 0; ex_pc = 0;
      step(mk(4'b0000, 4'b0001, 0, 0, 32'h1C, 2, 1, 0, 5));
      step(mk(4'b0000, 4'b0000, 0, 0, 32'h1C, 2, 1, 0, 5));

      ex_en = 1; ex_eret = 1;
      step(mk(4'b0000, 4'b0111, 1, 32'h1C, 32'h1C, 2, 1, 0, 5));
      ex_en = 0; ex_eret = 0;
      step(mk(4'b0000, 4'b0000, 0, 0, 32'h1C, 2, 0, 0, 5));

      // Enter handler, then fault again inside it.
      ex_en = 1; ex_exp_code = 3'd3; ex_pc = 32'h20;
      step(mk(4'b0000, 4'b1111, 1, 32'h100, 32'h1C, 2, 0, 0, 5));
      ex_en = 0; ex_exp_code = 0;
      step(mk(4'b0000, 4'b0001, 0, 0, 32'h20, 3, 1, 0, 5));
      ex_en = 1; ex_exp_code = 3'd5; ex_pc = 32'h24;
      step(mk(4'b0000, 4'b1111, 0, 0, 32'h20, 3, 1, 0, 5));
      ex_en = 0; ex_exp_code = 0; br_taken = 1; br_target = 32'h80;
      cnt = 5;
      for (int i = 0; i < 12; i++) begin
         step(mk(4'b1111, 4'b0000, 0, 0, 32'h20, 3, 1, 1, cnt));
         cnt = cnt + 1;
      end

      idle_inputs();
      reset = 1;
      step(mk(4'b0000, 4'b1111, 0, 0, 0, 0, 0, 0, 0));
      reset = 0;
      step(mk(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
